// File: rtl/mux4_scan_sequencer_pkg.sv
// Shared encodings and limits for the 4:1 mux scan sequencer.
// No logic; no latency; no backpressure.
`ifndef MUX4_SCAN_SEQUENCER_PKG_SV
`define MUX4_SCAN_SEQUENCER_PKG_SV
package mux4_scan_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam int         SETTLE_MIN = 1;
    localparam int         SETTLE_MAX = 16;
    localparam logic [1:0] LAST_CH    = 2'd3;

endpackage
`endif

// File: rtl/mux4_scan_sequencer_settle_counter.sv
// Loadable down-counter with zero flag; times the per-channel settle window.
// Latency: load/decrement visible one cycle after the edge.
// Backpressure: none; dec at zero holds the count at zero.
module mux4_scan_sequencer_settle_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux4_scan_sequencer.sv
// Steps a 4:1 mux select through channels 0..3 and packs the samples into a word.
// Latency: valid one cycle after edge E0+4*SETTLE_CYCLES following start acceptance.
// Backpressure: none; start while busy is dropped, valid is a single-cycle strobe.
module mux4_scan_sequencer
    import mux4_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CW            = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic [3:0] sample,
    output logic       valid,
    output logic       busy
);

    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    scan_state_t state_q, state_d;
    logic [1:0]  sel_d;
    logic [2:0]  shadow_q, shadow_d;
    logic [3:0]  sample_d;
    logic        valid_d;
    logic        cnt_load, cnt_dec, cnt_zero;

    mux4_scan_sequencer_settle_counter #(
        .CW (CW)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (RELOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel;
        shadow_d = shadow_q;
        sample_d = sample;
        valid_d  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = 2'd0;
                if (start) begin
                    state_d  = SCAN;
                    cnt_load = 1'b1;
                end
            end
            SCAN: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (sel != LAST_CH) begin
                    shadow_d[sel] = mux_out;
                    sel_d         = sel + 2'd1;
                    cnt_load      = 1'b1;
                end else begin
                    // Last channel goes straight into the word so sample never shows a partial scan.
                    sample_d = {mux_out, shadow_q};
                    valid_d  = 1'b1;
                    shadow_d = 3'b000;
                    sel_d    = 2'd0;
                    if (continuous) begin
                        cnt_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel      <= 2'd0;
            shadow_q <= 3'b000;
            sample   <= 4'h0;
            valid    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel      <= sel_d;
            shadow_q <= shadow_d;
            sample   <= sample_d;
            valid    <= valid_d;
        end
    end

    assign busy = (state_q == SCAN);

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Bench for mux4_scan_sequencer: two instances (settle 2 and settle 1) each behind a 4:1 mux.
// A scan-level model predicts every output each cycle; directed checks pin hand-computed values.
module tb_mux4_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st   [2];
    logic       ct   [2];
    logic [3:0] iv   [2];
    logic       mx   [2];
    logic [1:0] selo [2];
    logic [3:0] smp  [2];
    logic       vld  [2];
    logic       bsy  [2];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign mx[0] = iv[0][selo[0]];
    assign mx[1] = iv[1][selo[1]];

    mux4_scan_sequencer #(.SETTLE_CYCLES(2), .CW(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .continuous(ct[0]), .mux_out(mx[0]),
        .sel(selo[0]), .sample(smp[0]), .valid(vld[0]), .busy(bsy[0])
    );

    mux4_scan_sequencer #(.SETTLE_CYCLES(1), .CW(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .continuous(ct[1]), .mux_out(mx[1]),
        .sel(selo[1]), .sample(smp[1]), .valid(vld[1]), .busy(bsy[1])
    );

    function automatic int settle_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scan-level model: counts edges since acceptance, captures channel inputs at window ends.
    bit         m_busy   [2];
    int         m_n      [2];
    logic [3:0] m_word   [2];
    logic [3:0] m_sample [2];
    bit         m_valid  [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            if (!rst_n) begin
                m_busy[d]   = 1'b0;
                m_n[d]      = 0;
                m_word[d]   = 4'h0;
                m_sample[d] = 4'h0;
            end else if (!m_busy[d]) begin
                if (st[d]) begin
                    m_busy[d] = 1'b1;
                    m_n[d]    = 0;
                    m_word[d] = 4'h0;
                end
            end else begin
                m_n[d] = m_n[d] + 1;
                if (m_n[d] % settle_of(d) == 0)
                    m_word[d][m_n[d] / settle_of(d) - 1] = iv[d][m_n[d] / settle_of(d) - 1];
                if (m_n[d] == 4 * settle_of(d)) begin
                    m_valid[d]  = 1'b1;
                    m_sample[d] = m_word[d];
                    m_word[d]   = 4'h0;
                    m_n[d]      = 0;
                    if (!ct[d]) m_busy[d] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d.sel", d), 32'(selo[d]),
                    m_busy[d] ? 32'((m_n[d] / settle_of(d)) % 4) : 32'd0);
                chk($sformatf("d%0d.busy", d), 32'(bsy[d]), 32'(m_busy[d]));
                chk($sformatf("d%0d.valid", d), 32'(vld[d]), 32'(m_valid[d]));
                chk($sformatf("d%0d.sample", d), 32'(smp[d]), 32'(m_sample[d]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input int d);
        st[d] = 1'b1;
        tick();
        st[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, input int lim, output int cyc);
        cyc = 0;
        while (!vld[d] && cyc < lim) begin
            tick();
            cyc++;
        end
        chk($sformatf("d%0d.valid_seen", d), 32'(vld[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nv;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0;
            ct[d] = 1'b0;
            iv[d] = 4'h0;
        end

        // Reset, then idle with start low.
        tick();
        tick();
        chk("rst.sel", 32'(selo[0]), 32'd0);
        chk("rst.sample", 32'(smp[0]), 32'h0);
        chk("rst.valid", 32'(vld[0]), 32'd0);
        chk("rst.busy", 32'(bsy[0]), 32'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        repeat (3) tick();
        chk("idle.busy", 32'(bsy[0]), 32'd0);

        // Single scan, channel pattern 1010.
        iv[0] = 4'b1010;
        pulse_start(0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("single.sel%0d", k), 32'(selo[0]), 32'(k / 2));
            tick();
        end
        chk("single.valid", 32'(vld[0]), 32'd1);
        chk("single.sample", 32'(smp[0]), 32'hA);
        tick();
        chk("single.busy_after", 32'(bsy[0]), 32'd0);
        chk("single.valid_once", 32'(vld[0]), 32'd0);

        // Continuous mode, input change between scans, then drop continuous.
        iv[0] = 4'b0110;
        ct[0] = 1'b1;
        pulse_start(0);
        wait_valid(0, 20, cyc);
        chk("cont.lat1", 32'(cyc), 32'd8);
        chk("cont.sample1", 32'(smp[0]), 32'h6);
        iv[0] = 4'b1001;
        tick();
        wait_valid(0, 20, cyc);
        chk("cont.lat2", 32'(cyc), 32'd7);
        chk("cont.sample2", 32'(smp[0]), 32'h9);
        ct[0] = 1'b0;
        tick();
        chk("cont.busy_nogap", 32'(bsy[0]), 32'd1);
        wait_valid(0, 20, cyc);
        chk("cont.sample3", 32'(smp[0]), 32'h9);
        tick();
        chk("cont.idle", 32'(bsy[0]), 32'd0);

        // start held during a scan does not queue another scan.
        iv[0] = 4'b1100;
        st[0] = 1'b1;
        repeat (6) tick();
        st[0] = 1'b0;
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            if (vld[0]) nv++;
            tick();
        end
        chk("repeat.valid_count", 32'(nv), 32'd1);
        chk("repeat.sample", 32'(smp[0]), 32'hC);
        chk("repeat.idle", 32'(bsy[0]), 32'd0);

        // start in the valid cycle is accepted immediately.
        iv[0] = 4'b0011;
        pulse_start(0);
        wait_valid(0, 20, cyc);
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        chk("back2back.busy", 32'(bsy[0]), 32'd1);
        wait_valid(0, 20, cyc);
        chk("back2back.lat", 32'(cyc), 32'd8);
        chk("back2back.sample", 32'(smp[0]), 32'h3);
        tick();

        // Reset mid-scan while sel==2 discards the scan.
        iv[0] = 4'b0111;
        pulse_start(0);
        cyc = 0;
        while (selo[0] != 2'd2 && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("midrst.reached_sel2", 32'(selo[0]), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst.sel", 32'(selo[0]), 32'd0);
        chk("midrst.busy", 32'(bsy[0]), 32'd0);
        chk("midrst.sample", 32'(smp[0]), 32'h0);
        chk("midrst.valid", 32'(vld[0]), 32'd0);
        tick();
        iv[0] = 4'hF;
        pulse_start(0);
        wait_valid(0, 20, cyc);
        chk("midrst.lat", 32'(cyc), 32'd8);
        chk("midrst.sample_f", 32'(smp[0]), 32'hF);
        tick();

        // Settle window of one cycle.
        iv[1] = 4'b0101;
        pulse_start(1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s1.sel%0d", k), 32'(selo[1]), 32'(k));
            tick();
        end
        chk("s1.valid", 32'(vld[1]), 32'd1);
        chk("s1.sample", 32'(smp[1]), 32'h5);
        tick();
        chk("s1.idle", 32'(bsy[1]), 32'd0);
        repeat (2) tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
